// File: rtl/mmio_peripheral_pkg.sv
// mmio_peripheral_pkg
//   Shared constants for the memory-mapped peripheral block:
//   - register word indices (addr[5:2]) inside the peripheral window
//   - bit positions inside TCON and UART_CON
//   - state encoding shared by the UART transmit and receive FSMs
package mmio_peripheral_pkg;

    // Word index of each register (byte offset / 4).
    localparam logic [3:0] REG_TH      = 4'h0;  // 0x00
    localparam logic [3:0] REG_TL      = 4'h1;  // 0x04
    localparam logic [3:0] REG_TCON    = 4'h2;  // 0x08
    localparam logic [3:0] REG_LED     = 4'h3;  // 0x0C
    localparam logic [3:0] REG_SWITCH  = 4'h4;  // 0x10
    localparam logic [3:0] REG_DIGI    = 4'h5;  // 0x14
    localparam logic [3:0] REG_TXD     = 4'h6;  // 0x18
    localparam logic [3:0] REG_RXD     = 4'h7;  // 0x1C
    localparam logic [3:0] REG_UARTCON = 4'h8;  // 0x20

    // TCON bit positions.
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    // UART_CON bit positions.
    localparam int UCON_TX_DONE    = 0;
    localparam int UCON_RX_READY   = 1;
    localparam int UCON_TX_BUSY    = 2;
    localparam int UCON_RX_OVERRUN = 3;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/mmio_peripheral_if.sv
// mmio_peripheral_if
//   MEM-stage bus as seen by the peripheral block.
//   rd/wr   : read and write strobes
//   addr    : byte address
//   wdata   : store data
//   rdata   : combinational read data returned to the MEM-stage mux
//   master  : the CPU side (drives strobes/address/data)
//   slave   : the peripheral side (returns rdata)
interface mmio_peripheral_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/mmio_peripheral_uart_core.sv
// uart_core
//   8N1 UART: transmit FSM, receive FSM with a two-flop synchroniser,
//   and their baud counters.
//   clk, reset     : core clock, asynchronous active-low reset
//   tx_start       : one-cycle request to send tx_data (honoured only when idle)
//   tx_data        : byte to send
//   tx_busy        : transmitter is not idle
//   tx_done_pulse  : high in the last cycle of the stop bit
//   rx_data        : most recently assembled byte
//   rx_valid_pulse : high for one cycle when a byte with a good stop bit completes
//   uart_rx        : asynchronous serial input
//   uart_tx        : serial output, idle high
module uart_core
    import mmio_peripheral_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done_pulse,
    output logic [7:0] rx_data,
    output logic       rx_valid_pulse,
    input  logic       uart_rx,
    output logic       uart_tx
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    uart_state_e   txState_q;
    logic [CW-1:0] txCnt_q;
    logic [2:0]    txBit_q;
    logic [7:0]    txShift_q;
    logic          txLine_q;

    uart_state_e   rxState_q;
    logic [CW-1:0] rxCnt_q;
    logic [2:0]    rxBit_q;
    logic [7:0]    rxShift_q;
    logic          rxSync1_q;
    logic          rxSync2_q;
    logic          rxPrev_q;

    // Transmit FSM. The serial line is registered and updated on the same
    // edge that changes state, so it never glitches between bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txState_q <= UART_IDLE;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txShift_q <= '0;
            txLine_q  <= 1'b1;
        end else begin
            case (txState_q)
                UART_IDLE: begin
                    if (tx_start) begin
                        txState_q <= UART_START;
                        txShift_q <= tx_data;
                        txCnt_q   <= '0;
                        txLine_q  <= 1'b0;
                    end
                end
                UART_START: begin
                    if (txCnt_q == BIT_LAST) begin
                        txState_q <= UART_DATA;
                        txCnt_q   <= '0;
                        txBit_q   <= '0;
                        txLine_q  <= txShift_q[0];
                    end else begin
                        txCnt_q <= txCnt_q + CNT_ONE;
                    end
                end
                UART_DATA: begin
                    if (txCnt_q == BIT_LAST) begin
                        txCnt_q <= '0;
                        if (txBit_q == 3'd7) begin
                            txState_q <= UART_STOP;
                            txLine_q  <= 1'b1;
                        end else begin
                            txBit_q   <= txBit_q + 3'd1;
                            txShift_q <= {1'b0, txShift_q[7:1]};
                            txLine_q  <= txShift_q[1];
                        end
                    end else begin
                        txCnt_q <= txCnt_q + CNT_ONE;
                    end
                end
                UART_STOP: begin
                    if (txCnt_q == BIT_LAST) begin
                        txState_q <= UART_IDLE;
                        txCnt_q   <= '0;
                        txLine_q  <= 1'b1;
                    end else begin
                        txCnt_q <= txCnt_q + CNT_ONE;
                    end
                end
                default: begin
                    txState_q <= UART_IDLE;
                    txLine_q  <= 1'b1;
                end
            endcase
        end
    end

    assign tx_busy       = (txState_q != UART_IDLE);
    assign tx_done_pulse = (txState_q == UART_STOP) && (txCnt_q == BIT_LAST);
    assign uart_tx       = txLine_q;

    // Receive FSM. rxPrev_q trails the synchronised line by one cycle so a
    // falling edge can be seen. The start bit is re-checked half a bit in,
    // and every later sample lands a whole bit after the previous one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxSync1_q <= 1'b1;
            rxSync2_q <= 1'b1;
            rxPrev_q  <= 1'b1;
            rxState_q <= UART_IDLE;
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxShift_q <= '0;
        end else begin
            rxSync1_q <= uart_rx;
            rxSync2_q <= rxSync1_q;
            rxPrev_q  <= rxSync2_q;
            case (rxState_q)
                UART_IDLE: begin
                    if (rxPrev_q && !rxSync2_q) begin
                        rxState_q <= UART_START;
                        rxCnt_q   <= '0;
                    end
                end
                UART_START: begin
                    if (rxCnt_q == HALF_LAST) begin
                        rxCnt_q <= '0;
                        rxBit_q <= '0;
                        if (rxSync2_q) begin
                            rxState_q <= UART_IDLE;
                        end else begin
                            rxState_q <= UART_DATA;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q + CNT_ONE;
                    end
                end
                UART_DATA: begin
                    if (rxCnt_q == BIT_LAST) begin
                        rxCnt_q   <= '0;
                        rxShift_q <= {rxSync2_q, rxShift_q[7:1]};
                        if (rxBit_q == 3'd7) begin
                            rxState_q <= UART_STOP;
                        end else begin
                            rxBit_q <= rxBit_q + 3'd1;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q + CNT_ONE;
                    end
                end
                UART_STOP: begin
                    if (rxCnt_q == BIT_LAST) begin
                        rxState_q <= UART_IDLE;
                        rxCnt_q   <= '0;
                    end else begin
                        rxCnt_q <= rxCnt_q + CNT_ONE;
                    end
                end
                default: begin
                    rxState_q <= UART_IDLE;
                end
            endcase
        end
    end

    assign rx_data        = rxShift_q;
    assign rx_valid_pulse = (rxState_q == UART_STOP) && (rxCnt_q == BIT_LAST) && rxSync2_q;

endmodule

// File: rtl/mmio_peripheral.sv
// mmio_peripheral
//   Memory-mapped register window holding a reloadable timer, LED/switch/
//   7-segment registers and an 8N1 UART.
//   clk, reset : core clock, asynchronous active-low reset
//   bus        : MEM-stage bus (rd, wr, addr, wdata in; rdata out, combinational)
//   led        : LED register
//   switch     : switch inputs (read-only register)
//   digi       : 7-segment drive register
//   irqout     : timer interrupt request
//   UART_RX    : asynchronous serial input
//   UART_TX    : serial output, idle high
module mmio_peripheral
    import mmio_peripheral_pkg::*;
#(
    parameter int          BAUD_DIV = 5208,
    parameter logic [31:0] BASE     = 32'h4000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    mmio_peripheral_if.slave       bus,
    output logic [7:0]             led,
    input  logic [7:0]             switch,
    output logic [11:0]            digi,
    output logic                   irqout,
    input  logic                   UART_RX,
    output logic                   UART_TX
);

    logic [31:0] th_q,        th_d;
    logic [31:0] tl_q,        tl_d;
    logic [2:0]  tcon_q,      tcon_d;
    logic [7:0]  led_q,       led_d;
    logic [11:0] digi_q,      digi_d;
    logic [7:0]  txd_q,       txd_d;
    logic [7:0]  rxd_q,       rxd_d;
    logic        txDone_q,    txDone_d;
    logic        rxReady_q,   rxReady_d;
    logic        rxOverrun_q, rxOverrun_d;

    logic        hit;
    logic [3:0]  regSel;
    logic        wrEn;
    logic        rdEn;
    logic        txStart;
    logic        txBusy;
    logic        txDonePulse;
    logic [7:0]  rxData;
    logic        rxValidPulse;
    logic        rxRead;
    logic        unusedAddrBits;

    // Only the upper address bits select the window; byte lanes are ignored.
    assign hit            = (bus.addr[31:6] == BASE[31:6]);
    assign regSel         = bus.addr[5:2];
    assign wrEn           = bus.wr && hit;
    assign rdEn           = bus.rd && hit;
    assign rxRead         = rdEn && (regSel == REG_RXD);
    assign txStart        = wrEn && (regSel == REG_TXD) && !txBusy;
    assign unusedAddrBits = ^bus.addr[1:0];

    uart_core #(
        .BAUD_DIV (BAUD_DIV)
    ) uUartCore (
        .clk            (clk),
        .reset          (reset),
        .tx_start       (txStart),
        .tx_data        (bus.wdata[7:0]),
        .tx_busy        (txBusy),
        .tx_done_pulse  (txDonePulse),
        .rx_data        (rxData),
        .rx_valid_pulse (rxValidPulse),
        .uart_rx        (UART_RX),
        .uart_tx        (UART_TX)
    );

    // Read mux: zero-latency, zero for anything not mapped or not strobed.
    always_comb begin
        bus.rdata = '0;
        if (rdEn) begin
            case (regSel)
                REG_TH:      bus.rdata = th_q;
                REG_TL:      bus.rdata = tl_q;
                REG_TCON:    bus.rdata = {29'd0, tcon_q};
                REG_LED:     bus.rdata = {24'd0, led_q};
                REG_SWITCH:  bus.rdata = {24'd0, switch};
                REG_DIGI:    bus.rdata = {20'd0, digi_q};
                REG_TXD:     bus.rdata = {24'd0, txd_q};
                REG_RXD:     bus.rdata = {24'd0, rxd_q};
                REG_UARTCON: bus.rdata = {28'd0, rxOverrun_q, txBusy, rxReady_q, txDone_q};
                default:     bus.rdata = '0;
            endcase
        end
    end

    // Next-state for the register file. The timer is evaluated first so that
    // a CPU write to TL/TCON in the same cycle overrides it. For the UART
    // flags, event-driven sets are applied last so they beat clears.
    always_comb begin
        th_d        = th_q;
        tl_d        = tl_q;
        tcon_d      = tcon_q;
        led_d       = led_q;
        digi_d      = digi_q;
        txd_d       = txd_q;
        rxd_d       = rxd_q;
        txDone_d    = txDone_q;
        rxReady_d   = rxReady_q;
        rxOverrun_d = rxOverrun_q;

        if (tcon_q[TCON_EN]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[TCON_IE]) begin
                    tcon_d[TCON_IS] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        if (wrEn) begin
            case (regSel)
                REG_TH:      th_d   = bus.wdata;
                REG_TL:      tl_d   = bus.wdata;
                REG_TCON:    tcon_d = bus.wdata[2:0];
                REG_LED:     led_d  = bus.wdata[7:0];
                REG_DIGI:    digi_d = bus.wdata[11:0];
                REG_UARTCON: begin
                    if (!bus.wdata[UCON_TX_DONE]) begin
                        txDone_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (txStart) begin
            txd_d    = bus.wdata[7:0];
            txDone_d = 1'b0;
        end
        if (txDonePulse) begin
            txDone_d = 1'b1;
        end

        if (rxRead) begin
            rxReady_d   = 1'b0;
            rxOverrun_d = 1'b0;
        end
        if (rxValidPulse) begin
            rxd_d     = rxData;
            rxReady_d = 1'b1;
            if (rxReady_q) begin
                rxOverrun_d = 1'b1;
            end
        end
    end

    // Register file state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q        <= '0;
            tl_q        <= '0;
            tcon_q      <= '0;
            led_q       <= '0;
            digi_q      <= '0;
            txd_q       <= '0;
            rxd_q       <= '0;
            txDone_q    <= 1'b0;
            rxReady_q   <= 1'b0;
            rxOverrun_q <= 1'b0;
        end else begin
            th_q        <= th_d;
            tl_q        <= tl_d;
            tcon_q      <= tcon_d;
            led_q       <= led_d;
            digi_q      <= digi_d;
            txd_q       <= txd_d;
            rxd_q       <= rxd_d;
            txDone_q    <= txDone_d;
            rxReady_q   <= rxReady_d;
            rxOverrun_q <= rxOverrun_d;
        end
    end

    assign irqout = tcon_q[TCON_IS] & tcon_q[TCON_IE];
    assign led    = led_q;
    assign digi   = digi_q;

endmodule

// File: tb/tb_mmio_peripheral.sv
// tb_mmio_peripheral
//   Directed bench for mmio_peripheral with a 4-clock UART bit time.
//   Each feature has its own task with hand-computed expectations.
module tb_mmio_peripheral;

    localparam logic [31:0] A_TH      = 32'h4000_0000;
    localparam logic [31:0] A_TL      = 32'h4000_0004;
    localparam logic [31:0] A_TCON    = 32'h4000_0008;
    localparam logic [31:0] A_LED     = 32'h4000_000C;
    localparam logic [31:0] A_SWITCH  = 32'h4000_0010;
    localparam logic [31:0] A_DIGI    = 32'h4000_0014;
    localparam logic [31:0] A_TXD     = 32'h4000_0018;
    localparam logic [31:0] A_RXD     = 32'h4000_001C;
    localparam logic [31:0] A_UARTCON = 32'h4000_0020;

    logic        clk;
    logic        reset;
    logic [7:0]  led;
    logic [7:0]  switch;
    logic [11:0] digi;
    logic        irqout;
    logic        UART_RX;
    logic        UART_TX;

    int passCount;
    int checkCount;

    mmio_peripheral_if bus ();

    mmio_peripheral #(
        .BAUD_DIV (4),
        .BASE     (32'h4000_0000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .led     (led),
        .switch  (switch),
        .digi    (digi),
        .irqout  (irqout),
        .UART_RX (UART_RX),
        .UART_TX (UART_TX)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single write cycle: drive on the falling edge, committed on the next rising edge.
    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr    = 1'b1;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
    endtask

    // Combinational read without crossing a clock edge.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.rd   = 1'b1;
        #1;
        d = bus.rdata;
        bus.rd = 1'b0;
    endtask

    // Serial frame on UART_RX at 4 clocks per bit.
    task automatic sendRxByte(input logic [7:0] b, input logic stopBit);
        logic [9:0] f;
        f = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            UART_RX = f[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        UART_RX = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        peek(A_TL, d);
        checkCount++; if (d !== 32'h0) $display("[TB] FAIL reset_tl: got %h expected %h", d, 32'h0); else passCount++;
        peek(A_TCON, d);
        checkCount++; if (d !== 32'h0) $display("[TB] FAIL reset_tcon: got %h expected %h", d, 32'h0); else passCount++;
        peek(A_LED, d);
        checkCount++; if (d !== 32'h0) $display("[TB] FAIL reset_led_reg: got %h expected %h", d, 32'h0); else passCount++;
        checkCount++; if (UART_TX !== 1'b1) $display("[TB] FAIL reset_uart_tx: got %b expected 1", UART_TX); else passCount++;
        checkCount++; if (irqout !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", irqout); else passCount++;
        checkCount++; if (digi !== 12'h0) $display("[TB] FAIL reset_digi: got %h expected 000", digi); else passCount++;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_timer();
        logic [31:0] d;
        busWrite(A_TH, 32'hFFFF_FFFD);
        busWrite(A_TL, 32'hFFFF_FFFE);
        busWrite(A_TCON, 32'h3);
        peek(A_TL, d);
        checkCount++; if (d !== 32'hFFFF_FFFE) $display("[TB] FAIL timer_tl0: got %h expected %h", d, 32'hFFFF_FFFE); else passCount++;
        @(posedge clk); #1;
        peek(A_TL, d);
        checkCount++; if (d !== 32'hFFFF_FFFF) $display("[TB] FAIL timer_tl1: got %h expected %h", d, 32'hFFFF_FFFF); else passCount++;
        checkCount++; if (irqout !== 1'b0) $display("[TB] FAIL timer_irq_pre: got %b expected 0", irqout); else passCount++;
        @(posedge clk); #1;
        peek(A_TL, d);
        checkCount++; if (d !== 32'hFFFF_FFFD) $display("[TB] FAIL timer_reload: got %h expected %h", d, 32'hFFFF_FFFD); else passCount++;
        checkCount++; if (irqout !== 1'b1) $display("[TB] FAIL timer_irq_rise: got %b expected 1", irqout); else passCount++;
        peek(A_TCON, d);
        checkCount++; if (d !== 32'h7) $display("[TB] FAIL timer_tcon_status: got %h expected %h", d, 32'h7); else passCount++;
        @(posedge clk); #1;
        peek(A_TL, d);
        checkCount++; if (d !== 32'hFFFF_FFFE) $display("[TB] FAIL timer_tl3: got %h expected %h", d, 32'hFFFF_FFFE); else passCount++;
        peek(A_TH, d);
        checkCount++; if (d !== 32'hFFFF_FFFD) $display("[TB] FAIL timer_th: got %h expected %h", d, 32'hFFFF_FFFD); else passCount++;
        // Clearing the status bit drops the request; TL moves on to FFFF_FFFF.
        busWrite(A_TCON, 32'h3);
        checkCount++; if (irqout !== 1'b0) $display("[TB] FAIL timer_irq_clear: got %b expected 0", irqout); else passCount++;
        // Write to TL on the overflow edge beats the reload.
        busWrite(A_TL, 32'h0000_1234);
        peek(A_TL, d);
        checkCount++; if (d !== 32'h0000_1234) $display("[TB] FAIL timer_tl_collision: got %h expected %h", d, 32'h0000_1234); else passCount++;
        busWrite(A_TCON, 32'h0);
        peek(A_TL, d);
        checkCount++; if (d !== 32'h0000_1235) $display("[TB] FAIL timer_tl_last_count: got %h expected %h", d, 32'h0000_1235); else passCount++;
        repeat (2) @(posedge clk);
        #1;
        peek(A_TL, d);
        checkCount++; if (d !== 32'h0000_1235) $display("[TB] FAIL timer_tl_hold: got %h expected %h", d, 32'h0000_1235); else passCount++;
        checkCount++; if (irqout !== 1'b0) $display("[TB] FAIL timer_irq_disabled: got %b expected 0", irqout); else passCount++;
    endtask

    task automatic test_gpio();
        logic [31:0] d;
        switch = 8'h3C;
        busWrite(A_LED, 32'h0000_00A5);
        busWrite(A_DIGI, 32'hFFFF_FFFF);
        checkCount++; if (led !== 8'hA5) $display("[TB] FAIL gpio_led: got %h expected %h", led, 8'hA5); else passCount++;
        checkCount++; if (digi !== 12'hFFF) $display("[TB] FAIL gpio_digi: got %h expected %h", digi, 12'hFFF); else passCount++;
        peek(A_SWITCH, d);
        checkCount++; if (d !== 32'h0000_003C) $display("[TB] FAIL gpio_switch: got %h expected %h", d, 32'h0000_003C); else passCount++;
        busWrite(A_SWITCH, 32'h0000_00FF);
        peek(A_SWITCH, d);
        checkCount++; if (d !== 32'h0000_003C) $display("[TB] FAIL gpio_switch_ro: got %h expected %h", d, 32'h0000_003C); else passCount++;
        checkCount++; if (led !== 8'hA5) $display("[TB] FAIL gpio_led_after_ro: got %h expected %h", led, 8'hA5); else passCount++;
        // Byte-lane bits are ignored by the decoder.
        peek(32'h4000_000F, d);
        checkCount++; if (d !== 32'h0000_00A5) $display("[TB] FAIL gpio_led_lane: got %h expected %h", d, 32'h0000_00A5); else passCount++;
        peek(32'h4000_0024, d);
        checkCount++; if (d !== 32'h0) $display("[TB] FAIL gpio_unmapped: got %h expected %h", d, 32'h0); else passCount++;
        busWrite(32'h0000_000C, 32'h0);
        checkCount++; if (led !== 8'hA5) $display("[TB] FAIL gpio_outside_window: got %h expected %h", led, 8'hA5); else passCount++;
    endtask

    task automatic test_uart_tx();
        logic [31:0] d;
        logic [9:0]  frame;
        frame = {1'b1, 8'h55, 1'b0};
        busWrite(A_TXD, 32'h0000_0055);
        peek(A_UARTCON, d);
        checkCount++; if (d !== 32'h4) $display("[TB] FAIL tx_busy_flag: got %h expected %h", d, 32'h4); else passCount++;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                checkCount++;
                if (UART_TX !== frame[b]) $display("[TB] FAIL tx_bit%0d_clk%0d: got %b expected %b", b, c, UART_TX, frame[b]);
                else passCount++;
                if (b == 3 && c == 0) begin
                    bus.addr  = A_TXD;
                    bus.wdata = 32'h0000_00FF;
                    bus.wr    = 1'b1;
                end
                @(posedge clk);
                #1;
                bus.wr = 1'b0;
            end
        end
        peek(A_UARTCON, d);
        checkCount++; if (d !== 32'h1) $display("[TB] FAIL tx_done_flag: got %h expected %h", d, 32'h1); else passCount++;
        peek(A_TXD, d);
        checkCount++; if (d !== 32'h0000_0055) $display("[TB] FAIL tx_dropped_write: got %h expected %h", d, 32'h0000_0055); else passCount++;
        repeat (4) @(posedge clk);
        #1;
        checkCount++; if (UART_TX !== 1'b1) $display("[TB] FAIL tx_idle_after: got %b expected 1", UART_TX); else passCount++;
        busWrite(A_UARTCON, 32'h0);
        peek(A_UARTCON, d);
        checkCount++; if (d !== 32'h0) $display("[TB] FAIL tx_done_clear: got %h expected %h", d, 32'h0); else passCount++;
    endtask

    task automatic test_uart_rx();
        logic [31:0] d;
        sendRxByte(8'hC3, 1'b1);
        peek(A_UARTCON, d);
        checkCount++; if (d !== 32'h2) $display("[TB] FAIL rx_ready: got %h expected %h", d, 32'h2); else passCount++;
        // Read RXD across an edge so the flags clear.
        @(negedge clk);
        bus.addr = A_RXD;
        bus.rd   = 1'b1;
        #1;
        d = bus.rdata;
        checkCount++; if (d !== 32'h0000_00C3) $display("[TB] FAIL rx_data: got %h expected %h", d, 32'h0000_00C3); else passCount++;
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
        peek(A_UARTCON, d);
        checkCount++; if (d !== 32'h0) $display("[TB] FAIL rx_ready_clear: got %h expected %h", d, 32'h0); else passCount++;

        sendRxByte(8'h5A, 1'b1);
        sendRxByte(8'hA5, 1'b1);
        peek(A_UARTCON, d);
        checkCount++; if (d !== 32'hA) $display("[TB] FAIL rx_overrun: got %h expected %h", d, 32'hA); else passCount++;
        peek(A_RXD, d);
        checkCount++; if (d !== 32'h0000_00A5) $display("[TB] FAIL rx_overrun_data: got %h expected %h", d, 32'h0000_00A5); else passCount++;
        @(negedge clk);
        bus.addr = A_RXD;
        bus.rd   = 1'b1;
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
        peek(A_UARTCON, d);
        checkCount++; if (d !== 32'h0) $display("[TB] FAIL rx_overrun_clear: got %h expected %h", d, 32'h0); else passCount++;

        // Bad stop bit: byte dropped, flags untouched.
        sendRxByte(8'h11, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        peek(A_UARTCON, d);
        checkCount++; if (d !== 32'h0) $display("[TB] FAIL rx_framing_flags: got %h expected %h", d, 32'h0); else passCount++;
        peek(A_RXD, d);
        checkCount++; if (d !== 32'h0000_00A5) $display("[TB] FAIL rx_framing_data: got %h expected %h", d, 32'h0000_00A5); else passCount++;

        // One-clock low glitch is rejected at the start-bit re-check.
        @(negedge clk);
        UART_RX = 1'b0;
        @(negedge clk);
        UART_RX = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        peek(A_UARTCON, d);
        checkCount++; if (d !== 32'h0) $display("[TB] FAIL rx_glitch_flags: got %h expected %h", d, 32'h0); else passCount++;

        sendRxByte(8'h3C, 1'b1);
        peek(A_RXD, d);
        checkCount++; if (d !== 32'h0000_003C) $display("[TB] FAIL rx_after_glitch: got %h expected %h", d, 32'h0000_003C); else passCount++;
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] d;
        logic [9:0]  frame;
        busWrite(A_TXD, 32'h0000_00AA);
        @(posedge clk);
        #1;
        checkCount++; if (UART_TX !== 1'b0) $display("[TB] FAIL midtx_start_bit: got %b expected 0", UART_TX); else passCount++;
        #2;
        reset = 1'b0;
        #1;
        checkCount++; if (UART_TX !== 1'b1) $display("[TB] FAIL midtx_line_idle: got %b expected 1", UART_TX); else passCount++;
        checkCount++; if (led !== 8'h00) $display("[TB] FAIL midtx_led: got %h expected 00", led); else passCount++;
        peek(A_UARTCON, d);
        checkCount++; if (d !== 32'h0) $display("[TB] FAIL midtx_uartcon: got %h expected %h", d, 32'h0); else passCount++;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        frame = {1'b1, 8'h0F, 1'b0};
        busWrite(A_TXD, 32'h0000_000F);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 1) begin
                    checkCount++;
                    if (UART_TX !== frame[b]) $display("[TB] FAIL retx_bit%0d: got %b expected %b", b, UART_TX, frame[b]);
                    else passCount++;
                end
                @(posedge clk);
                #1;
            end
        end
        peek(A_UARTCON, d);
        checkCount++; if (d !== 32'h1) $display("[TB] FAIL retx_done: got %h expected %h", d, 32'h1); else passCount++;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        reset      = 1'b0;
        switch     = 8'h00;
        UART_RX    = 1'b1;
        bus.rd     = 1'b0;
        bus.wr     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;

        $display("[TB] starting");
        test_reset();
        test_timer();
        test_gpio();
        test_uart_tx();
        test_uart_rx();
        test_reset_mid_tx();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
